// File: rtl/bp_be_stride_prefetcher_if.sv
// Discovery-event inputs and dcache prefetch handshake of the stride prefetcher.
// master = detector/dcache side, slave = prefetcher.
interface bp_be_stride_prefetcher_if #(
    parameter int unsigned vaddr_width_p    = 39,
    parameter int unsigned eff_addr_width_p = 39,
    parameter int unsigned stride_width_p   = 8
);
    logic                        start_discovery_i;
    logic                        confirm_discovery_i;
    logic [vaddr_width_p-1:0]    striding_pc_i;
    logic [eff_addr_width_p-1:0] eff_addr_i;
    logic [stride_width_p-1:0]   stride_i;
    logic                        pf_v_o;
    logic [eff_addr_width_p-1:0] pf_addr_o;
    logic                        pf_ready_i;

    modport master (
        output start_discovery_i, confirm_discovery_i, striding_pc_i, eff_addr_i, stride_i,
        output pf_ready_i,
        input  pf_v_o, pf_addr_o
    );

    modport slave (
        input  start_discovery_i, confirm_discovery_i, striding_pc_i, eff_addr_i, stride_i,
        input  pf_ready_i,
        output pf_v_o, pf_addr_o
    );
endinterface

// File: rtl/bp_be_stride_prefetcher.sv
// Stride prefetcher: records confirmed streams in a small table and issues a bounded
// number of same-page prefetch addresses per confirmation over a valid/ready port.
module bp_be_stride_prefetcher #(
    parameter int unsigned vaddr_width_p       = 39,
    parameter int unsigned eff_addr_width_p    = 39,
    parameter int unsigned stride_width_p      = 8,
    parameter int unsigned streams_p           = 4,
    parameter int unsigned degree_p            = 2,
    parameter int unsigned page_offset_width_p = 12
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    bp_be_stride_prefetcher_if.slave    pf_if,
    output logic [$clog2(streams_p):0]  active_streams_o,
    output logic                        busy_o
);
    localparam int unsigned ptr_w_lp  = $clog2(streams_p);
    localparam int unsigned cnt_w_lp  = ptr_w_lp + 1;
    localparam int unsigned ext_w_lp  = eff_addr_width_p - stride_width_p;
    localparam int unsigned page_w_lp = eff_addr_width_p - page_offset_width_p;

    typedef logic [eff_addr_width_p-1:0] addr_t;
    typedef logic [ptr_w_lp-1:0]         ptr_t;
    typedef enum logic {e_idle, e_req} state_e;

    state_e                    state_q, state_d;
    logic [streams_p-1:0]      v_q, v_d;
    logic [vaddr_width_p-1:0]  pc_q        [streams_p];
    logic [vaddr_width_p-1:0]  pc_d        [streams_p];
    addr_t                     next_addr_q [streams_p];
    addr_t                     next_addr_d [streams_p];
    logic [stride_width_p-1:0] stride_q    [streams_p];
    logic [stride_width_p-1:0] stride_d    [streams_p];
    logic [2:0]                rem_q       [streams_p];
    logic [2:0]                rem_d       [streams_p];
    logic [page_w_lp-1:0]      page_q      [streams_p];
    logic [page_w_lp-1:0]      page_d      [streams_p];
    ptr_t                      victim_q, victim_d, last_q, last_d;
    addr_t                     pf_addr_q, pf_addr_d;
    logic                      skip_q, skip_d;

    logic  cfm_v, hit_v, free_v, pick_v, hs;
    ptr_t  hit_idx, free_idx, wr_idx, pick_idx, scan_idx;
    addr_t cfm_next, hs_next;
    logic  unused_train;

    // Training pulses carry no state in this block.
    assign unused_train = pf_if.start_discovery_i;

    function automatic addr_t sext(input logic [stride_width_p-1:0] s);
        return {{ext_w_lp{s[stride_width_p-1]}}, s};
    endfunction

    // Confirm target: matching pc, else lowest free entry, else round-robin victim.
    always_comb begin : target_sel
        cfm_v    = pf_if.confirm_discovery_i && (pf_if.stride_i != '0);
        hit_v    = 1'b0;
        hit_idx  = '0;
        free_v   = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < streams_p; i++) begin
            if (!hit_v && v_q[i] && (pc_q[i] == pf_if.striding_pc_i)) begin
                hit_v   = 1'b1;
                hit_idx = ptr_w_lp'(i);
            end
            if (!free_v && !v_q[i]) begin
                free_v   = 1'b1;
                free_idx = ptr_w_lp'(i);
            end
        end
        wr_idx = hit_v ? hit_idx : (free_v ? free_idx : victim_q);
    end

    // Round-robin scan for an entry with work left, starting after the last served one.
    always_comb begin : issue_pick
        pick_v   = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int unsigned k = 1; k <= streams_p; k++) begin
            scan_idx = last_q + ptr_w_lp'(k);
            if (!pick_v && (rem_q[scan_idx] != 3'd0)) begin
                pick_v   = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    // skip_q marks a served entry rewritten by a confirm; its handshake update is dropped.
    always_comb begin : fsm_next
        state_d   = state_q;
        pf_addr_d = pf_addr_q;
        last_d    = last_q;
        skip_d    = skip_q;
        hs        = 1'b0;
        case (state_q)
            e_idle: begin
                if (pick_v) begin
                    pf_addr_d = next_addr_q[pick_idx];
                    last_d    = pick_idx;
                    skip_d    = cfm_v && (wr_idx == pick_idx);
                    state_d   = e_req;
                end
            end
            e_req: begin
                if (pf_if.pf_ready_i) begin
                    hs      = 1'b1;
                    skip_d  = 1'b0;
                    state_d = e_idle;
                end else begin
                    skip_d = skip_q || (cfm_v && (wr_idx == last_q));
                end
            end
            default: state_d = e_idle;
        endcase
    end

    // Table update: handshake advance first, a confirm write to the same entry wins.
    always_comb begin : table_next
        v_d         = v_q;
        pc_d        = pc_q;
        next_addr_d = next_addr_q;
        stride_d    = stride_q;
        rem_d       = rem_q;
        page_d      = page_q;
        victim_d    = victim_q;
        hs_next     = next_addr_q[last_q] + sext(stride_q[last_q]);
        cfm_next    = pf_if.eff_addr_i + sext(pf_if.stride_i);
        if (hs && !skip_q) begin
            next_addr_d[last_q] = hs_next;
            rem_d[last_q] = ((hs_next[eff_addr_width_p-1:page_offset_width_p] != page_q[last_q])
                             || (rem_q[last_q] == 3'd0)) ? 3'd0 : rem_q[last_q] - 3'd1;
        end
        if (cfm_v) begin
            v_d[wr_idx]         = 1'b1;
            pc_d[wr_idx]        = pf_if.striding_pc_i;
            stride_d[wr_idx]    = pf_if.stride_i;
            next_addr_d[wr_idx] = cfm_next;
            page_d[wr_idx]      = pf_if.eff_addr_i[eff_addr_width_p-1:page_offset_width_p];
            rem_d[wr_idx] = (cfm_next[eff_addr_width_p-1:page_offset_width_p]
                             != pf_if.eff_addr_i[eff_addr_width_p-1:page_offset_width_p])
                            ? 3'd0 : 3'(degree_p);
            if (!hit_v && !free_v) begin
                victim_d = victim_q + ptr_w_lp'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin : regs
        if (!reset_n_i) begin
            state_q   <= e_idle;
            v_q       <= '0;
            victim_q  <= '0;
            last_q    <= '0;
            pf_addr_q <= '0;
            skip_q    <= 1'b0;
            for (int unsigned i = 0; i < streams_p; i++) begin
                pc_q[i]        <= '0;
                next_addr_q[i] <= '0;
                stride_q[i]    <= '0;
                rem_q[i]       <= '0;
                page_q[i]      <= '0;
            end
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            victim_q    <= victim_d;
            last_q      <= last_d;
            pf_addr_q   <= pf_addr_d;
            skip_q      <= skip_d;
            pc_q        <= pc_d;
            next_addr_q <= next_addr_d;
            stride_q    <= stride_d;
            rem_q       <= rem_d;
            page_q      <= page_d;
        end
    end

    assign pf_if.pf_v_o    = (state_q == e_req);
    assign pf_if.pf_addr_o = pf_addr_q;

    always_comb begin : status
        active_streams_o = '0;
        for (int unsigned i = 0; i < streams_p; i++) begin
            if (rem_q[i] != 3'd0) begin
                active_streams_o = active_streams_o + cnt_w_lp'(1);
            end
        end
        busy_o = (state_q == e_req) || (active_streams_o != '0);
    end
endmodule

// File: doc/bp_be_stride_prefetcher.md
Name: bp_be_stride_prefetcher

Overview:
- Consumes discovery events from the backend stride detector: start/confirm pulses carrying the striding PC, the last effective address and the stride.
- Keeps a small table of confirmed streams.
- Issues a bounded number of prefetch addresses per confirmation to the dcache prefetch port over a valid/ready handshake.
- Sits between the checker-side stride detector and the dcache request arbiter.

Parameters:
- vaddr_width_p, 39, PC width.
- eff_addr_width_p, 39, effective/prefetch address width.
- stride_width_p, 8, signed stride width in bytes.
- streams_p, 4, stream table entries (power of two, at least 2).
- degree_p, 2, prefetches issued per confirmation (1..7).
- page_offset_width_p, 12, page size log2; prefetches never cross a page.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- start_discovery_i  in  1  detector saw a stride candidate (training event).
- confirm_discovery_i  in  1  detector confirmed a steady stride.
- striding_pc_i  in  vaddr_width_p  PC of the striding memory op.
- eff_addr_i  in  eff_addr_width_p  most recent effective address of that PC.
- stride_i  in  stride_width_p  signed stride (two's complement).
- pf_v_o  out  1  prefetch request valid.
- pf_addr_o  out  eff_addr_width_p  prefetch address.
- pf_ready_i  in  1  dcache accepts the request.
- active_streams_o  out  $clog2(streams_p)+1  count of entries with remaining > 0.
- busy_o  out  1  pf_v_o high or any remaining > 0.

Behaviour:
- Reset: asserting reset_n_i low clears immediately, without waiting for a clock edge:
  - all entry valid bits, remaining counters and the round-robin/victim pointers;
  - the FSM, which returns to IDLE;
  - outputs: pf_v_o=0, pf_addr_o=0, active_streams_o=0, busy_o=0.
- Reset mid-handshake: the pending request is dropped and not re-issued.
- Entry contents: v, pc, next_addr, stride, remaining (3 bits), page (upper address bits).
- Event priority: if start and confirm are high together, treat the cycle as a confirm only.
- start_discovery_i alone: no table or output change; counted as training only (ignored).
- confirm_discovery_i with stride_i == 0: ignored.
- confirm_discovery_i with nonzero stride, applied at the sampling edge:
  - Entry selection: the entry with matching pc; otherwise the lowest-index invalid entry; otherwise the round-robin victim, after which the victim pointer increments mod streams_p.
  - Entry write: pc=striding_pc_i; stride=sign-extended stride_i; next_addr=eff_addr_i+stride (mod 2^eff_addr_width_p); page=eff_addr_i[top:page_offset_width_p]; remaining=degree_p.
  - If next_addr lies outside page, remaining is written as 0.
- Issue FSM has two states:
  - IDLE: if any entry has remaining > 0, pick one by round-robin from the last-served index + 1; latch its next_addr into pf_addr_o, set pf_v_o=1, go to REQ.
  - REQ: pf_v_o and pf_addr_o are held stable until pf_ready_i=1.
  - On the handshake edge, the served entry is updated: next_addr += stride; remaining -= 1; remaining forced to 0 if the new next_addr leaves the entry's page. The FSM then returns to IDLE.
- Handshake throughput: at most one request per two cycles.
- Latency: a confirm sampled at edge k gives pf_v_o=1 after edge k+1 (write at k, select at k+1).
- Confirm hitting the entry currently in REQ:
  - The table overwrite wins; the handshake update for that entry is discarded.
  - The held pf_addr_o still completes unchanged.
- Address arithmetic wraps modulo 2^eff_addr_width_p, but the page check blocks any prefetch whose page differs from the page of the confirming eff_addr.
- active_streams_o and busy_o are combinational from state.

Test Plan:
- Basic issue: confirm with pc=0x100, eff_addr=0x1000, stride=8, pf_ready_i tied 1 -> exactly two handshakes, addresses 0x1008 then 0x1010; then pf_v_o=0, busy_o=0; first pf_v_o=1 two edges after confirm.
- Backpressure and ignored events: hold pf_ready_i=0 for 5 cycles with pf_addr_o=0x1008 -> pf_v_o and pf_addr_o stay stable; release gives 0x1008 then 0x1010. Separately, start-only pulses and a stride=0 confirm -> no pf_v_o.
- Negative stride and page edge: confirm eff_addr=0x2010, stride=-16 (0xF0) -> single prefetch 0x2000; the next address 0x1FF0 crosses the page, so no second request. Confirm eff_addr=0x2FF8, stride=8 -> no prefetch.
- Table full: confirms for 5 distinct PCs with ready=0 -> the 5th replaces entry 0; active_streams_o saturates at 4 and never exceeds it.
- Confirm during REQ: the same PC reconfirmed while 0x1008 is held -> 0x1008 completes, then 0x1010 and 0x1018 are issued, since the table overwrite reloaded remaining.
- Async reset: pull reset_n_i low between clock edges while pf_v_o=1 -> pf_v_o=0 immediately; after release, no request until a new confirm.
